// File: rtl/uart_tx_fifo_if.sv
// Producer-side port bundle for uart_tx_fifo: one word with a valid/ready
// handshake, plus the number of words currently queued.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 8
);
    logic [DATA_BITS-1:0]        data_in;
    logic                        data_valid;
    logic                        data_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  fifo_count
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO. Frame format (data bits, parity, stop
// bits) is fixed by parameters; queued words go out back-to-back.
// tx and busy are registered from the FSM state, so both lag the state by one
// cycle and change only on bit boundaries.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave host,
    output logic          tx,
    output logic          busy
);
    localparam int unsigned BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W      = $clog2(BIT_PERIOD);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W      = PTR_W + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(FIFO_DEPTH);
    localparam logic             PAR_EN     = (PARITY != 0);
    localparam logic             PAR_ODD    = (PARITY == 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]     count_q, count_d;

    logic                 push;
    logic                 pop;
    logic                 not_full;
    logic                 not_empty;
    logic                 bit_done;
    logic [DATA_BITS-1:0] head;

    assign not_full  = (count_q != FULL_COUNT);
    assign not_empty = (count_q != '0);
    assign push      = host.data_valid && not_full;
    assign head      = mem[rd_ptr_q];
    assign bit_done  = (baud_q == BAUD_LAST);

    // A pop frees a slot only from the next cycle on, so push and pop never
    // both apply to a full FIFO; the count just nets the two.
    assign count_d = count_q + OCC_W'(push) - OCC_W'(pop);

    assign host.data_ready = not_full;
    assign host.fifo_count = count_q;
    assign tx              = tx_q;
    assign busy            = busy_q;

    // Next-state logic: frame sequencing, baud/bit counting and FIFO pops.
    always_comb begin
        state_d  = state_q;
        baud_d   = bit_done ? '0 : baud_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (not_empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    bit_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next frame when work is queued.
                        if (not_empty) begin
                            pop     = 1'b1;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Parity is taken from the whole word at pop time, before any shifting.
        if (pop) begin
            shift_d  = head;
            parity_d = (^head) ^ PAR_ODD;
        end
    end

    // Line level and busy flag derived from the current state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != StIdle);
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
            StParity: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // State, counters, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr_q] <= host.data_in;
        end
    end
endmodule
